// File: rtl/onescount_pkg.sv
// Shared definitions for the serial word deserializer and the ones counter it feeds.
package onescount_pkg;

    localparam int WORD_W = 7;
    localparam int CNT_W  = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        COL_IDLE  = 1'b0,
        COL_SHIFT = 1'b1
    } col_state_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/serial_word_deser_word_out_buf.sv
// One-entry output register with valid/ready handshake.
// A completed word is dropped, and overrun is set, when the buffer is full
// and the consumer is not taking the current word.
module word_out_buf
    import onescount_pkg::buf_state_t;
    import onescount_pkg::BUF_EMPTY;
    import onescount_pkg::BUF_FULL;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             ready,
    input  logic             overrun_clr,
    output logic             valid,
    output logic [WIDTH-1:0] word,
    output logic             overrun
);

    buf_state_t       state;
    buf_state_t       state_next;
    logic [WIDTH-1:0] word_next;
    logic             overrun_next;
    logic             drop;

    // State, data and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BUF_EMPTY;
            word    <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            word    <= word_next;
            overrun <= overrun_next;
        end
    end

    // Load / consume / drop decisions; a drop wins over a same-cycle clear.
    always_comb begin
        state_next   = state;
        word_next    = word;
        drop         = 1'b0;
        if (load) begin
            if (state == BUF_EMPTY || ready) begin
                // Empty, or the held word is consumed this cycle: no bubble.
                word_next  = load_word;
                state_next = BUF_FULL;
            end else begin
                drop = 1'b1;
            end
        end else if (state == BUF_FULL && ready) begin
            state_next = BUF_EMPTY;
        end

        if (drop) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun;
        end
    end

    assign valid = (state == BUF_FULL);

endmodule

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word assembler, MSB first, feeding a registered
// output buffer. The collector FSM lives here; buffering is in word_out_buf.
module serial_word_deser
    import onescount_pkg::col_state_t;
    import onescount_pkg::COL_IDLE;
    import onescount_pkg::COL_SHIFT;
#(
    parameter int WIDTH = onescount_pkg::WORD_W,
    parameter int CNT_W = onescount_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_bit,
    input  logic             abort,
    input  logic             overrun_clr,
    input  logic             word_ready,
    output logic             word_valid,
    output logic [WIDTH-1:0] word,
    output logic             busy,
    output logic             overrun
);

    col_state_t       state;
    col_state_t       state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             word_done;
    logic [WIDTH-1:0] done_word;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Collector registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COL_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
        end
    end

    // Next-state: abort beats an incoming bit; the WIDTH-th bit completes a word.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        word_done    = 1'b0;
        done_word    = {shreg[WIDTH-2:0], ser_bit};
        if (abort) begin
            state_next   = COL_IDLE;
            bit_cnt_next = '0;
            shreg_next   = '0;
        end else if (ser_valid) begin
            shreg_next = {shreg[WIDTH-2:0], ser_bit};
            if (bit_cnt == LAST_CNT) begin
                word_done    = 1'b1;
                bit_cnt_next = '0;
                state_next   = COL_IDLE;
            end else begin
                bit_cnt_next = bit_cnt + CNT_W'(1);
                state_next   = COL_SHIFT;
            end
        end
    end

    assign busy = (state == COL_SHIFT);

    word_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (word_done),
        .load_word   (done_word),
        .ready       (word_ready),
        .overrun_clr (overrun_clr),
        .valid       (word_valid),
        .word        (word),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed bench for serial_word_deser.
module tb_serial_word_deser;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ser_valid = 1'b0;
    logic         ser_bit = 1'b0;
    logic         abort = 1'b0;
    logic         overrun_clr = 1'b0;
    logic         word_ready = 1'b0;
    logic         word_valid;
    logic [W-1:0] word;
    logic         busy;
    logic         overrun;

    int vectors = 0;
    int miscompares = 0;

    serial_word_deser #(.WIDTH(W), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ser_valid   (ser_valid),
        .ser_bit     (ser_bit),
        .abort       (abort),
        .overrun_clr (overrun_clr),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word        (word),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // One clock with the current inputs; outputs settle #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_valid = 1'b1;
        ser_bit   = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (word_valid !== 1'b0 || word !== 7'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: valid=%b word=%b busy=%b overrun=%b, required 0 0000000 0 0",
                     word_valid, word, busy, overrun);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] pat;
        pat = 7'b1010011;
        word_ready = 1'b1;
        for (int i = W - 1; i >= 1; i--) send_bit(pat[i]);
        vectors++;
        if (word_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_partial: valid=%b busy=%b, required 0 1", word_valid, busy);
        end
        send_bit(pat[0]);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b1010011 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_word: valid=%b word=%b busy=%b, required 1 1010011 0",
                     word_valid, word, busy);
        end
        vectors++;
        if (3'($countones(word)) !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_count: got %b, required 100", 3'($countones(word)));
        end
        tick();
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_one_cycle: valid=%b, required 0", word_valid);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] pat;
        int bad;
        pat = 7'b0111101;
        bad = 0;
        word_ready = 1'b1;
        for (int i = W - 1; i >= 1; i--) begin
            send_bit(pat[i]);
            tick();
            if (busy !== 1'b1 || word_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL gapped_busy: %0d gap cycles with busy!=1 or valid!=0, required 0", bad);
        end
        send_bit(pat[0]);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b0111101 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gapped_word: valid=%b word=%b busy=%b, required 1 0111101 0",
                     word_valid, word, busy);
        end
        tick();
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_word(7'b1111111);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b1111111 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_first: valid=%b word=%b overrun=%b, required 1 1111111 0",
                     word_valid, word, overrun);
        end
        send_word(7'b0000111);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b1111111 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drop: valid=%b word=%b overrun=%b, required 1 1111111 1",
                     word_valid, word, overrun);
        end
        tick();
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_sticky: overrun=%b, required 1", overrun);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || word !== 7'b1111111) begin
            miscompares++;
            $display("FAIL bp_clear: overrun=%b word=%b, required 0 1111111", overrun, word);
        end
        word_ready = 1'b1;
        tick();
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: valid=%b, required 0", word_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] nxt;
        nxt = 7'b0010000;
        word_ready = 1'b0;
        send_word(7'b1000010);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b1000010) begin
            miscompares++;
            $display("FAIL b2b_hold: valid=%b word=%b, required 1 1000010", word_valid, word);
        end
        for (int i = W - 1; i >= 1; i--) send_bit(nxt[i]);
        word_ready = 1'b1;
        send_bit(nxt[0]);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b0010000 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_swap: valid=%b word=%b overrun=%b, required 1 0010000 0",
                     word_valid, word, overrun);
        end
        tick();
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: valid=%b, required 0", word_valid);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] pat;
        pat = 7'b1011111;
        word_ready = 1'b1;
        for (int i = W - 1; i >= W - 4; i--) send_bit(pat[i]);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: busy=%b, required 1", busy);
        end
        abort     = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = 1'b1;
        tick();
        abort     = 1'b0;
        ser_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: busy=%b valid=%b, required 0 0", busy, word_valid);
        end
        send_word(7'b0110011);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b0110011) begin
            miscompares++;
            $display("FAIL abort_word: valid=%b word=%b, required 1 0110011", word_valid, word);
        end
        tick();
    endtask

    task automatic test_midframe_reset();
        word_ready = 1'b0;
        send_word(7'b0101010);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (word_valid !== 1'b0 || word !== 7'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: valid=%b word=%b busy=%b overrun=%b, required 0 0000000 0 0",
                     word_valid, word, busy, overrun);
        end
        word_ready = 1'b1;
        send_word(7'b1100101);
        vectors++;
        if (word_valid !== 1'b1 || word !== 7'b1100101 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_clean: valid=%b word=%b busy=%b, required 1 1100101 0",
                     word_valid, word, busy);
        end
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
